ahb_slave_interface: RTL and testbench
======================================

Name: ahb_slave_interface

Overview:
AHB-side front end of the AHB-to-APB bridge. It sits directly upstream of the APB FSM controller. It qualifies AHB transfers and decodes the target APB slave. It pipelines address, write data and direction two deep to give the controller its current and previous beats. It also generates the AHB error response for unmapped or illegal transfers, and muxes Hreadyout and Hrdata back to the master.

Parameters:
SLV0_BASE, 32'h8000_0000, base of APB slave 0 region
SLV1_BASE, 32'h8400_0000, base of APB slave 1 region
SLV2_BASE, 32'h8800_0000, base of APB slave 2 region
REGION_SIZE, 32'h0400_0000, size of each slave region in bytes (power of two)

Ports:
Hclk  in  1  AHB clock
Hresetn  in  1  asynchronous active-low reset
Htrans  in  2  AHB transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ)
Hwrite  in  1  AHB direction, 1 = write
Hsize  in  3  AHB transfer size
Haddr  in  32  AHB address
Hwdata  in  32  AHB write data
Hreadyin  in  1  AHB HREADY seen by this slave
Hreadyout_apb  in  1  ready from APB FSM controller
Prdata  in  32  APB read data
valid  out  1  qualified transfer to controller
Haddr1  out  32  address pipeline stage 1
Haddr2  out  32  address pipeline stage 2
Hwdata1  out  32  write data pipeline stage 1
Hwdata2  out  32  write data pipeline stage 2
Hwritereg  out  1  registered Hwrite
tempselx  out  3  one-hot APB slave select
Hreadyout  out  1  HREADYOUT to AHB master
Hresp  out  2  AHB response (00 OKAY, 01 ERROR)
Hrdata  out  32  read data to AHB master

Behaviour:
- Clock is Hclk. Reset is Hresetn, asynchronous and active-low. All flops clear immediately on Hresetn low.
- Reset values: Haddr1, Haddr2, Hwdata1, Hwdata2 = 0; Hwritereg = 0; response FSM = OKAY; Hresp = 00.
  - valid = 0 during reset.
  - Hreadyout follows Hreadyout_apb during reset.
- Active transfer: Htrans[1] = 1 (NONSEQ or SEQ) and Hreadyin = 1. IDLE and BUSY are never active.
- Decode, combinational on Haddr:
  - Slave n is hit when SLVn_BASE <= Haddr < SLVn_BASE + REGION_SIZE.
  - tempselx = 001 / 010 / 100 for slave 0 / 1 / 2, else 000.
  - tempselx is driven regardless of Htrans.
- Legal transfer: Hsize <= 3'b010 and the address is aligned.
  - Halfword requires Haddr[0] = 0.
  - Word requires Haddr[1:0] = 00.
- valid, combinational:
  - 1 when the transfer is active, tempselx != 0, it is legal, and the FSM is OKAY.
  - Same-cycle path; the controller samples it on the next edge.
- Pipeline, on posedge Hclk when Hreadyin = 1:
  - Haddr1 <= Haddr, Haddr2 <= Haddr1.
  - Hwdata1 <= Hwdata, Hwdata2 <= Hwdata1.
  - Hwritereg <= Hwrite.
  - When Hreadyin = 0, all pipeline registers hold.
- Response FSM states: OKAY, ERR1, ERR2.
  - OKAY -> ERR1 when the transfer is active and (tempselx = 0 or illegal); otherwise stay.
  - ERR1 -> ERR2 unconditionally.
  - ERR2 -> OKAY unconditionally.
  - An erroring transfer never asserts valid.
- Outputs per state:
  - OKAY: Hreadyout = Hreadyout_apb, Hresp = 00.
  - ERR1: Hreadyout = 0, Hresp = 01.
  - ERR2: Hreadyout = 1, Hresp = 01.
  - This gives the AHB two-cycle error response.
- During ERR1 and ERR2, valid = 0 and any new Htrans is ignored. The master must re-present it (or drive IDLE) after ERR2.
- Hrdata = Prdata, combinational passthrough, all states.
- Simultaneous events:
  - An illegal transfer arriving while Hreadyin = 0 is not active and does not start an error.
  - Reset asserted in ERR1 or ERR2 returns to OKAY with Hresp = 00 immediately.
- Boundaries:
  - Address SLV2_BASE + REGION_SIZE - 4 decodes to slave 2.
  - SLV2_BASE + REGION_SIZE decodes to no slave (error).
  - Address 32'hFFFF_FFFF must not wrap into a hit.

Test Plan:
- Reset: assert Hresetn = 0 mid-cycle with a non-zero pipeline -> Haddr1/2, Hwdata1/2 = 0, Hresp = 00 and valid = 0 without waiting for a clock edge.
- Write burst: NONSEQ write 0x8000_0000 then SEQ 0x8000_0004 with data 0xA5A5_0001 / 0xA5A5_0002, Hreadyin = 1 -> valid = 1 and tempselx = 001 on both beats; after the 2nd edge Haddr1 = 0x8000_0004, Haddr2 = 0x8000_0000, Hwritereg = 1.
- Decode: single reads to 0x8400_0010 and 0x8BFF_FFFC -> tempselx = 010 and 100, valid = 1; IDLE to 0x8400_0010 -> valid = 0, tempselx = 010.
- Unmapped: NONSEQ read 0x9000_0000 -> valid = 0; next cycle Hreadyout = 0, Hresp = 01; following cycle Hreadyout = 1, Hresp = 01; then OKAY with Hreadyout = Hreadyout_apb.
- Illegal size/align: word write to 0x8000_0002, then Hsize = 011 to 0x8000_0000 -> each produces the two-cycle ERROR and valid = 0; a halfword to 0x8000_0002 -> valid = 1.
- Stall: Hreadyin = 0 for 3 cycles with Haddr changing -> Haddr1/Haddr2 hold; Prdata = 0x1234_5678 -> Hrdata = 0x1234_5678 in the same cycle.

Source files
------------

// File: rtl/ahb_slave_interface_if.sv
// AHB-side bus bundle between the AHB master and the bridge front end.
interface ahb_slave_interface_if;
    logic [1:0]  Htrans;
    logic        Hwrite;
    logic [2:0]  Hsize;
    logic [31:0] Haddr;
    logic [31:0] Hwdata;
    logic        Hreadyin;
    logic        Hreadyout_apb;
    logic [31:0] Prdata;
    logic        valid;
    logic [31:0] Haddr1;
    logic [31:0] Haddr2;
    logic [31:0] Hwdata1;
    logic [31:0] Hwdata2;
    logic        Hwritereg;
    logic [2:0]  tempselx;
    logic        Hreadyout;
    logic [1:0]  Hresp;
    logic [31:0] Hrdata;

    modport slave (
        input  Htrans, Hwrite, Hsize, Haddr, Hwdata, Hreadyin, Hreadyout_apb, Prdata,
        output valid, Haddr1, Haddr2, Hwdata1, Hwdata2, Hwritereg, tempselx,
               Hreadyout, Hresp, Hrdata
    );

    modport master (
        output Htrans, Hwrite, Hsize, Haddr, Hwdata, Hreadyin, Hreadyout_apb, Prdata,
        input  valid, Haddr1, Haddr2, Hwdata1, Hwdata2, Hwritereg, tempselx,
               Hreadyout, Hresp, Hrdata
    );
endinterface

// File: rtl/ahb_slave_interface.sv
// AHB front end of the AHB-to-APB bridge: qualifies and decodes transfers,
// pipelines address/data two deep and produces the two-cycle AHB error response.
module ahb_slave_interface #(
    parameter logic [31:0] SLV0_BASE   = 32'h8000_0000,
    parameter logic [31:0] SLV1_BASE   = 32'h8400_0000,
    parameter logic [31:0] SLV2_BASE   = 32'h8800_0000,
    parameter logic [31:0] REGION_SIZE = 32'h0400_0000
) (
    input logic                  Hclk,
    input logic                  Hresetn,
    ahb_slave_interface_if.slave bus
);
    localparam int NUM_SLV = 3;
    localparam logic [NUM_SLV-1:0][31:0] SLV_BASE = {SLV2_BASE, SLV1_BASE, SLV0_BASE};

    typedef enum logic [1:0] {
        S_OKAY = 2'b00,
        S_ERR1 = 2'b01,
        S_ERR2 = 2'b10
    } resp_state_t;

    resp_state_t         state, state_nxt;
    logic [NUM_SLV-1:0]  hit;
    logic                active;
    logic                legal;
    logic                hreadyout_c;
    logic [1:0]          hresp_c;

    // Offset from each base is compared unsigned, so addresses below a base
    // wrap to huge offsets and can never alias into a region.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLV; gi++) begin : g_dec
            assign hit[gi] = (bus.Haddr - SLV_BASE[gi]) < REGION_SIZE;
        end
    endgenerate

    assign bus.tempselx = hit;
    assign active       = bus.Htrans[1] & bus.Hreadyin;

    always_comb begin
        legal = 1'b0;
        case (bus.Hsize)
            3'b000:  legal = 1'b1;
            3'b001:  legal = ~bus.Haddr[0];
            3'b010:  legal = (bus.Haddr[1:0] == 2'b00);
            default: legal = 1'b0;
        endcase
    end

    assign bus.valid  = Hresetn & active & (|hit) & legal & (state == S_OKAY);
    assign bus.Hrdata = bus.Prdata;

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            bus.Haddr1    <= '0;
            bus.Haddr2    <= '0;
            bus.Hwdata1   <= '0;
            bus.Hwdata2   <= '0;
            bus.Hwritereg <= 1'b0;
        end else if (bus.Hreadyin) begin
            bus.Haddr1    <= bus.Haddr;
            bus.Haddr2    <= bus.Haddr1;
            bus.Hwdata1   <= bus.Hwdata;
            bus.Hwdata2   <= bus.Hwdata1;
            bus.Hwritereg <= bus.Hwrite;
        end
    end

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) state <= S_OKAY;
        else          state <= state_nxt;
    end

    // New transfers are ignored while the error response is in flight.
    always_comb begin
        state_nxt   = state;
        hreadyout_c = bus.Hreadyout_apb;
        hresp_c     = 2'b00;
        case (state)
            S_OKAY: begin
                if (active && (!(|hit) || !legal)) state_nxt = S_ERR1;
            end
            S_ERR1: begin
                hreadyout_c = 1'b0;
                hresp_c     = 2'b01;
                state_nxt   = S_ERR2;
            end
            S_ERR2: begin
                hreadyout_c = 1'b1;
                hresp_c     = 2'b01;
                state_nxt   = S_OKAY;
            end
            default: state_nxt = S_OKAY;
        endcase
    end

    assign bus.Hreadyout = hreadyout_c;
    assign bus.Hresp     = hresp_c;
endmodule

// File: tb/tb_ahb_slave_interface.sv
// Bench for the AHB front end: directed scenarios plus a randomized run
// checked against a region/alignment reference model.
module tb_ahb_slave_interface;
    logic Hclk;
    logic Hresetn;
    int   n_checks = 0;
    int   n_fail   = 0;

    localparam logic [31:0] REGION = 32'h0400_0000;

    ahb_slave_interface_if ifc();

    ahb_slave_interface dut (
        .Hclk    (Hclk),
        .Hresetn (Hresetn),
        .bus     (ifc)
    );

    initial Hclk = 1'b0;
    always #5 Hclk = ~Hclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] m_base(input int i);
        case (i)
            0:       return 32'h8000_0000;
            1:       return 32'h8400_0000;
            default: return 32'h8800_0000;
        endcase
    endfunction

    function automatic logic [2:0] m_sel(input logic [31:0] a);
        logic [2:0]  s;
        logic [32:0] lo, hi;
        s = 3'b000;
        for (int i = 0; i < 3; i++) begin
            lo = {1'b0, m_base(i)};
            hi = lo + {1'b0, REGION};
            if ({1'b0, a} >= lo && {1'b0, a} < hi) s[i] = 1'b1;
        end
        return s;
    endfunction

    function automatic logic m_legal(input logic [2:0] sz, input logic [31:0] a);
        if (sz == 3'd0) return 1'b1;
        if (sz == 3'd1) return (a % 2) == 0;
        if (sz == 3'd2) return (a % 4) == 0;
        return 1'b0;
    endfunction

    task automatic drive(input logic [1:0] t, input logic w, input logic [2:0] s,
                         input logic [31:0] a, input logic [31:0] d, input logic ri);
        ifc.Htrans = t; ifc.Hwrite = w; ifc.Hsize = s;
        ifc.Haddr = a;  ifc.Hwdata = d; ifc.Hreadyin = ri;
    endtask

    task automatic test_reset();
        drive(2'b10, 1'b1, 3'd2, 32'h8000_0000, 32'hDEAD_0001, 1'b1);
        ifc.Hreadyout_apb = 1'b1;
        ifc.Prdata = 32'h0;
        Hresetn = 1'b0;
        #1;
        n_checks++; if (ifc.valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", ifc.valid); end
        n_checks++; if (ifc.Hresp !== 2'b00) begin n_fail++; $display("FAIL rst_hresp: got %b want 00", ifc.Hresp); end
        n_checks++; if (ifc.Hreadyout !== 1'b1) begin n_fail++; $display("FAIL rst_ready_hi: got %b want 1", ifc.Hreadyout); end
        ifc.Hreadyout_apb = 1'b0;
        #1;
        n_checks++; if (ifc.Hreadyout !== 1'b0) begin n_fail++; $display("FAIL rst_ready_lo: got %b want 0", ifc.Hreadyout); end
        ifc.Hreadyout_apb = 1'b1;
        @(negedge Hclk); Hresetn = 1'b1;
        @(posedge Hclk);
        @(negedge Hclk); drive(2'b11, 1'b1, 3'd2, 32'h8000_0004, 32'hDEAD_0002, 1'b1);
        @(posedge Hclk); #1;
        n_checks++; if (ifc.Haddr2 !== 32'h8000_0000) begin n_fail++; $display("FAIL rst_pre_haddr2: got %h want 80000000", ifc.Haddr2); end
        #2 Hresetn = 1'b0;
        #1;
        n_checks++; if (ifc.Haddr1 !== 32'h0 || ifc.Haddr2 !== 32'h0) begin n_fail++; $display("FAIL rst_async_haddr: got %h/%h want 0/0", ifc.Haddr1, ifc.Haddr2); end
        n_checks++; if (ifc.Hwdata1 !== 32'h0 || ifc.Hwdata2 !== 32'h0) begin n_fail++; $display("FAIL rst_async_hwdata: got %h/%h want 0/0", ifc.Hwdata1, ifc.Hwdata2); end
        n_checks++; if (ifc.Hwritereg !== 1'b0) begin n_fail++; $display("FAIL rst_async_hwritereg: got %b want 0", ifc.Hwritereg); end
        n_checks++; if (ifc.valid !== 1'b0) begin n_fail++; $display("FAIL rst_async_valid: got %b want 0", ifc.valid); end
        @(negedge Hclk); Hresetn = 1'b1;
        drive(2'b10, 1'b0, 3'd2, 32'h9000_0000, 32'h0, 1'b1);
        @(posedge Hclk); #1;
        n_checks++; if (ifc.Hresp !== 2'b01) begin n_fail++; $display("FAIL rst_err1_entry: got %b want 01", ifc.Hresp); end
        #2 Hresetn = 1'b0;
        #1;
        n_checks++; if (ifc.Hresp !== 2'b00 || ifc.Hreadyout !== 1'b1) begin n_fail++; $display("FAIL rst_in_err: got resp %b rdy %b want 00 1", ifc.Hresp, ifc.Hreadyout); end
        @(negedge Hclk); Hresetn = 1'b1;
        drive(2'b00, 1'b0, 3'd2, 32'h0, 32'h0, 1'b1);
        @(posedge Hclk);
    endtask

    task automatic test_write_burst();
        @(negedge Hclk); drive(2'b10, 1'b1, 3'd2, 32'h8000_0000, 32'hA5A5_0001, 1'b1);
        #1;
        n_checks++; if (ifc.valid !== 1'b1 || ifc.tempselx !== 3'b001) begin n_fail++; $display("FAIL burst_beat0: got valid %b sel %b want 1 001", ifc.valid, ifc.tempselx); end
        @(posedge Hclk);
        @(negedge Hclk); drive(2'b11, 1'b1, 3'd2, 32'h8000_0004, 32'hA5A5_0002, 1'b1);
        #1;
        n_checks++; if (ifc.valid !== 1'b1 || ifc.tempselx !== 3'b001) begin n_fail++; $display("FAIL burst_beat1: got valid %b sel %b want 1 001", ifc.valid, ifc.tempselx); end
        @(posedge Hclk); #1;
        n_checks++; if (ifc.Haddr1 !== 32'h8000_0004 || ifc.Haddr2 !== 32'h8000_0000) begin n_fail++; $display("FAIL burst_haddr: got %h/%h want 80000004/80000000", ifc.Haddr1, ifc.Haddr2); end
        n_checks++; if (ifc.Hwdata1 !== 32'hA5A5_0002 || ifc.Hwdata2 !== 32'hA5A5_0001) begin n_fail++; $display("FAIL burst_hwdata: got %h/%h want a5a50002/a5a50001", ifc.Hwdata1, ifc.Hwdata2); end
        n_checks++; if (ifc.Hwritereg !== 1'b1) begin n_fail++; $display("FAIL burst_hwritereg: got %b want 1", ifc.Hwritereg); end
    endtask

    task automatic test_decode();
        logic [31:0] addr [6] = '{32'h8400_0010, 32'h8BFF_FFFC, 32'h8C00_0000,
                                  32'hFFFF_FFFF, 32'h7FFF_FFFC, 32'h8400_0010};
        logic [1:0]  tr   [6] = '{2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00};
        logic [2:0]  esel [6] = '{3'b010, 3'b100, 3'b000, 3'b000, 3'b000, 3'b010};
        logic        ev   [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            @(negedge Hclk); drive(tr[i], 1'b0, 3'd2, addr[i], 32'h0, 1'b1);
            #1;
            n_checks++; if (ifc.tempselx !== esel[i] || ifc.valid !== ev[i]) begin
                n_fail++; $display("FAIL decode_%0d: addr %h got sel %b valid %b want %b %b", i, addr[i], ifc.tempselx, ifc.valid, esel[i], ev[i]);
            end
            @(posedge Hclk);
        end
    endtask

    task automatic test_unmapped();
        @(negedge Hclk); drive(2'b10, 1'b0, 3'd2, 32'h9000_0000, 32'h0, 1'b1);
        ifc.Hreadyout_apb = 1'b1;
        #1;
        n_checks++; if (ifc.valid !== 1'b0 || ifc.tempselx !== 3'b000) begin n_fail++; $display("FAIL unmap_req: got valid %b sel %b want 0 000", ifc.valid, ifc.tempselx); end
        @(posedge Hclk);
        @(negedge Hclk); drive(2'b10, 1'b0, 3'd2, 32'h8000_0000, 32'h0, 1'b1);
        #1;
        n_checks++; if (ifc.Hreadyout !== 1'b0 || ifc.Hresp !== 2'b01 || ifc.valid !== 1'b0) begin
            n_fail++; $display("FAIL unmap_err1: got rdy %b resp %b valid %b want 0 01 0", ifc.Hreadyout, ifc.Hresp, ifc.valid);
        end
        @(posedge Hclk);
        @(negedge Hclk); drive(2'b10, 1'b0, 3'd2, 32'h9000_0000, 32'h0, 1'b1);
        #1;
        n_checks++; if (ifc.Hreadyout !== 1'b1 || ifc.Hresp !== 2'b01 || ifc.valid !== 1'b0) begin
            n_fail++; $display("FAIL unmap_err2: got rdy %b resp %b valid %b want 1 01 0", ifc.Hreadyout, ifc.Hresp, ifc.valid);
        end
        @(posedge Hclk);
        @(negedge Hclk); drive(2'b00, 1'b0, 3'd2, 32'h0, 32'h0, 1'b1);
        ifc.Hreadyout_apb = 1'b0;
        #1;
        n_checks++; if (ifc.Hreadyout !== 1'b0 || ifc.Hresp !== 2'b00) begin n_fail++; $display("FAIL unmap_okay_lo: got rdy %b resp %b want 0 00", ifc.Hreadyout, ifc.Hresp); end
        ifc.Hreadyout_apb = 1'b1;
        #1;
        n_checks++; if (ifc.Hreadyout !== 1'b1) begin n_fail++; $display("FAIL unmap_okay_hi: got rdy %b want 1", ifc.Hreadyout); end
        @(posedge Hclk);
    endtask

    task automatic test_illegal();
        logic [31:0] addr [3] = '{32'h8000_0002, 32'h8000_0000, 32'h8C00_0000};
        logic [2:0]  sz   [3] = '{3'd2, 3'd3, 3'd2};
        for (int i = 0; i < 3; i++) begin
            @(negedge Hclk); drive(2'b10, 1'b1, sz[i], addr[i], 32'h0, 1'b1);
            #1;
            n_checks++; if (ifc.valid !== 1'b0) begin n_fail++; $display("FAIL illegal_%0d_valid: got %b want 0", i, ifc.valid); end
            @(posedge Hclk);
            @(negedge Hclk); drive(2'b00, 1'b0, 3'd2, 32'h0, 32'h0, 1'b1);
            #1;
            n_checks++; if (ifc.Hreadyout !== 1'b0 || ifc.Hresp !== 2'b01) begin n_fail++; $display("FAIL illegal_%0d_err1: got rdy %b resp %b want 0 01", i, ifc.Hreadyout, ifc.Hresp); end
            @(posedge Hclk); #1;
            n_checks++; if (ifc.Hreadyout !== 1'b1 || ifc.Hresp !== 2'b01) begin n_fail++; $display("FAIL illegal_%0d_err2: got rdy %b resp %b want 1 01", i, ifc.Hreadyout, ifc.Hresp); end
            @(posedge Hclk); #1;
            n_checks++; if (ifc.Hresp !== 2'b00) begin n_fail++; $display("FAIL illegal_%0d_okay: got resp %b want 00", i, ifc.Hresp); end
        end
        @(negedge Hclk); drive(2'b10, 1'b1, 3'd1, 32'h8000_0002, 32'h0, 1'b1);
        #1;
        n_checks++; if (ifc.valid !== 1'b1 || ifc.tempselx !== 3'b001) begin n_fail++; $display("FAIL halfword: got valid %b sel %b want 1 001", ifc.valid, ifc.tempselx); end
        @(posedge Hclk);
        @(negedge Hclk); drive(2'b10, 1'b1, 3'd3, 32'h8000_0001, 32'h0, 1'b0);
        #1;
        n_checks++; if (ifc.valid !== 1'b0) begin n_fail++; $display("FAIL stalled_illegal_valid: got %b want 0", ifc.valid); end
        @(posedge Hclk); #1;
        n_checks++; if (ifc.Hresp !== 2'b00 || ifc.Hreadyout !== 1'b1) begin n_fail++; $display("FAIL stalled_illegal_resp: got resp %b rdy %b want 00 1", ifc.Hresp, ifc.Hreadyout); end
    endtask

    task automatic test_stall();
        @(negedge Hclk); drive(2'b10, 1'b1, 3'd2, 32'h8000_0100, 32'h0000_0011, 1'b1);
        @(posedge Hclk);
        @(negedge Hclk); drive(2'b11, 1'b1, 3'd2, 32'h8000_0104, 32'h0000_0022, 1'b1);
        @(posedge Hclk);
        for (int k = 0; k < 3; k++) begin
            @(negedge Hclk); drive(2'b10, 1'b0, 3'd2, 32'h8000_0200 + 32'(k * 4), 32'h3000 + 32'(k), 1'b0);
            ifc.Prdata = (k == 0) ? 32'h1234_5678 : $urandom;
            #1;
            n_checks++; if (ifc.Hrdata !== ifc.Prdata || ifc.valid !== 1'b0) begin
                n_fail++; $display("FAIL stall_%0d_comb: got rdata %h valid %b want %h 0", k, ifc.Hrdata, ifc.valid, ifc.Prdata);
            end
            @(posedge Hclk); #1;
            n_checks++; if (ifc.Haddr1 !== 32'h8000_0104 || ifc.Haddr2 !== 32'h8000_0100 ||
                            ifc.Hwdata1 !== 32'h22 || ifc.Hwdata2 !== 32'h11 || ifc.Hwritereg !== 1'b1) begin
                n_fail++; $display("FAIL stall_%0d_hold: got %h/%h %h/%h w%b want 80000104/80000100 22/11 w1",
                                   k, ifc.Haddr1, ifc.Haddr2, ifc.Hwdata1, ifc.Hwdata2, ifc.Hwritereg);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] a1, a2, d1, d2, addr, wd, pr;
        logic [1:0]  tr;
        logic [2:0]  sz, esel;
        logic        wr, w, ri, apb, el, eact, ev;
        int          err, r;
        @(negedge Hclk); Hresetn = 1'b0;
        drive(2'b00, 1'b0, 3'd0, 32'h0, 32'h0, 1'b1);
        #2 Hresetn = 1'b1;
        a1 = 0; a2 = 0; d1 = 0; d2 = 0; wr = 0; err = 0;
        for (int n = 0; n < 400; n++) begin
            @(negedge Hclk);
            r = $urandom_range(0, 5);
            if (r <= 2)      addr = m_base(r) + ($urandom & (REGION - 1));
            else if (r == 3) addr = $urandom;
            else if (r == 4) addr = 32'h8C00_0000 - 32'($urandom_range(0, 8));
            else             addr = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
            tr  = 2'($urandom_range(0, 3));
            sz  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            w   = 1'($urandom_range(0, 1));
            wd  = $urandom;
            pr  = $urandom;
            ri  = ($urandom_range(0, 4) != 0);
            apb = 1'($urandom_range(0, 1));
            drive(tr, w, sz, addr, wd, ri);
            ifc.Hreadyout_apb = apb;
            ifc.Prdata = pr;
            #1;
            esel = m_sel(addr);
            el   = m_legal(sz, addr);
            eact = tr[1] && ri;
            ev   = eact && (esel != 3'b000) && el && (err == 0);
            n_checks++; if (ifc.valid !== ev) begin n_fail++; $display("FAIL rnd_%0d_valid: addr %h got %b want %b", n, addr, ifc.valid, ev); end
            n_checks++; if (ifc.tempselx !== esel) begin n_fail++; $display("FAIL rnd_%0d_sel: addr %h got %b want %b", n, addr, ifc.tempselx, esel); end
            n_checks++; if (ifc.Hreadyout !== ((err == 0) ? apb : (err == 2))) begin n_fail++; $display("FAIL rnd_%0d_ready: got %b err %0d apb %b", n, ifc.Hreadyout, err, apb); end
            n_checks++; if (ifc.Hresp !== ((err == 0) ? 2'b00 : 2'b01)) begin n_fail++; $display("FAIL rnd_%0d_resp: got %b err %0d", n, ifc.Hresp, err); end
            n_checks++; if (ifc.Hrdata !== pr) begin n_fail++; $display("FAIL rnd_%0d_rdata: got %h want %h", n, ifc.Hrdata, pr); end
            @(posedge Hclk);
            if (err == 1)      err = 2;
            else if (err == 2) err = 0;
            else if (eact && (esel == 3'b000 || !el)) err = 1;
            if (ri) begin a2 = a1; a1 = addr; d2 = d1; d1 = wd; wr = w; end
            #1;
            n_checks++; if (ifc.Haddr1 !== a1) begin n_fail++; $display("FAIL rnd_%0d_haddr1: got %h want %h", n, ifc.Haddr1, a1); end
            n_checks++; if (ifc.Haddr2 !== a2) begin n_fail++; $display("FAIL rnd_%0d_haddr2: got %h want %h", n, ifc.Haddr2, a2); end
            n_checks++; if (ifc.Hwdata1 !== d1) begin n_fail++; $display("FAIL rnd_%0d_hwdata1: got %h want %h", n, ifc.Hwdata1, d1); end
            n_checks++; if (ifc.Hwdata2 !== d2) begin n_fail++; $display("FAIL rnd_%0d_hwdata2: got %h want %h", n, ifc.Hwdata2, d2); end
            n_checks++; if (ifc.Hwritereg !== wr) begin n_fail++; $display("FAIL rnd_%0d_hwritereg: got %b want %b", n, ifc.Hwritereg, wr); end
        end
    endtask

    initial begin
        test_reset();
        test_write_burst();
        test_decode();
        test_unmapped();
        test_illegal();
        test_stall();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
